serial_negate_ctrl: RTL and testbench
=====================================

SERIAL_NEGATE_CTRL -- requirements
Module: serial_negate_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port reset  input  1: asynchronous, active-low reset; 0 = reset asserted.
REQ-004 Port in_valid  input  1: upstream word available on in_data.
REQ-005 Port in_ready  output  1: block can accept a word this cycle.
REQ-006 Port in_data  input  WIDTH: two's-complement operand.
REQ-007 Port out_valid  output  1: result present on out_data.
REQ-008 Port out_ready  input  1: downstream accepts result this cycle.
REQ-009 Port out_data  output  WIDTH: two's-complement negation of the accepted operand, modulo 2^WIDTH.
REQ-010 Port busy  output  1: high in SHIFT and DONE.
REQ-011 Port ovf  output  1: present only when SERIAL_NEG_OVF_EN is defined; overflow flag qualified by out_valid.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready SHALL capture in_data into the shift register, clear the bit counter, clear the core carry state and go to SHIFT.
REQ-014 SHIFT: in_ready=0; each cycle SHALL present shift-register LSB to the core, shift the operand right by one, and shift the core output into the result register MSB-side (right-shift).
REQ-015 The core SHALL compute out_bit = state XOR in_bit combinationally and update state <= state OR in_bit per enabled cycle (invert after first 1 seen, LSB-first).
REQ-016 After exactly WIDTH SHIFT cycles (counter == WIDTH-1), the FSM SHALL go to DONE; out_valid SHALL rise WIDTH clock edges after the accept edge.
REQ-017 DONE: out_valid=1; out_data and ovf SHALL hold stable until out_valid&out_ready, then go to IDLE.
REQ-018 The block SHALL NOT accept a new word in DONE; minimum spacing between accepts is WIDTH+2 cycles.
REQ-019 in_valid and in_data SHALL be ignored in SHIFT and DONE; out_ready SHALL be ignored in IDLE and SHIFT.
REQ-020 Operand 0 SHALL yield 0; operand -2^(WIDTH-1) SHALL yield itself.
REQ-021 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap during SHIFT.

Reset
REQ-022 While reset=0: state=IDLE, in_ready=0, out_valid=0, busy=0, out_data=0, ovf=0, counter=0, core state=0.
REQ-023 in_ready SHALL be 1 from the first rising edge after reset deasserts.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL discard the word with no out_valid pulse.

Configuration
REQ-025 With SERIAL_NEG_OVF_EN defined: ovf port exists; ovf=1 in DONE iff the operand was -2^(WIDTH-1) (MSB=1, other bits 0), tracked serially during SHIFT.
REQ-026 Without SERIAL_NEG_OVF_EN: no ovf port, no overflow-tracking logic; all other behaviour identical.

Structure
REQ-027 Package serial_neg_pkg SHALL hold the FSM state enum (IDLE/SHIFT/DONE) and the WIDTH default constant.
REQ-028 Sub-module serial_negate_core SHALL implement the one-bit-per-cycle negator with inputs clk, reset, clr (synchronous), en, in_bit and output out_bit.

Verification (WIDTH=8)
REQ-029 Accept 0x05, out_ready=1 -> out_valid after 8 edges, out_data=0xFB, ovf=0.
REQ-030 Accept 0x00 -> out_data=0x00, ovf=0; accept 0x80 -> out_data=0x80, ovf=1 (macro defined).
REQ-031 Back-pressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data=0xFB held stable; in_ready=0 throughout.
REQ-032 Reset pulsed low on the 3rd SHIFT cycle of 0x33 -> no out_valid; next word 0x01 -> 0xFF.
REQ-033 Back-to-back 0x01 then 0x7F with in_valid held high -> 0xFF then 0x81; second accept exactly WIDTH+2 cycles after the first.
REQ-034 in_valid toggled during SHIFT with random data -> result unaffected, no extra accept.

Source files
------------

// File: rtl/serial_negate_ctrl_pkg.sv
// Shared types and defaults for the bit-serial two's-complement negator.
package serial_neg_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_negate_ctrl_if.sv
// Operand/result handshake bundle for serial_negate_ctrl.
// The ovf signal exists only when SERIAL_NEG_OVF_EN is defined.
interface serial_negate_ctrl_if import serial_neg_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef SERIAL_NEG_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif

endinterface

// File: rtl/serial_negate_ctrl_core.sv
// One-bit-per-cycle negator: passes bits until the first 1, inverts after it.
module serial_negate_core (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic in_bit,
    output logic out_bit
);

    logic seen_one;

    assign out_bit = seen_one ^ in_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_one <= 1'b0;
        end else if (clr) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | in_bit;
        end
    end

endmodule

// File: rtl/serial_negate_ctrl.sv
// Bit-serial negation controller: accepts a word, negates it LSB-first over WIDTH cycles.
// Optional overflow flag (operand == most negative value) enabled by SERIAL_NEG_OVF_EN.
module serial_negate_ctrl import serial_neg_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_negate_ctrl_if.slave  bus
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic             started;
    logic             load;
    logic             shift_en;
    logic             last_bit;
    logic             core_out;
    logic             in_ready;
    logic             out_valid;
    logic             busy;

    assign last_bit = (bit_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid && started) next_state = SHIFT;
            SHIFT:   if (last_bit)                next_state = DONE;
            DONE:    if (bus.out_ready)           next_state = IDLE;
            default:                              next_state = IDLE;
        endcase
    end

    // Ready is held low until the first edge after reset so no word slips in during release.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = started;
                load     = bus.in_valid && started;
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operand <= '0;
            result  <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            operand <= bus.in_data;
            bit_cnt <= '0;
        end else if (shift_en) begin
            operand <= operand >> 1;
            result  <= {core_out, result[WIDTH-1:1]};
            if (!last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    serial_negate_core u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (load),
        .en      (shift_en),
        .in_bit  (operand[0]),
        .out_bit (core_out)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = result;
    assign bus.busy      = busy;

`ifdef SERIAL_NEG_OVF_EN
    logic low_zero;
    logic ovf_q;

    // Overflow only for 100..0: all lower bits zero, then a 1 in the final (MSB) position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_zero <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            low_zero <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (shift_en) begin
            if (last_bit) begin
                ovf_q <= low_zero & operand[0];
            end else if (operand[0]) begin
                low_zero <= 1'b0;
            end
        end
    end

    assign bus.ovf = ovf_q & out_valid;
`endif

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl against an arithmetic negation model.
// Overflow checks are compiled in when SERIAL_NEG_OVF_EN is defined.
module tb_serial_negate_ctrl;

    localparam int WIDTH = 8;
    localparam int MAX_WAIT = 50;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_negate_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_negate_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [WIDTH-1:0] ref_neg(input logic [WIDTH-1:0] x);
        int v;
        v = -int'(x);
        return v[WIDTH-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x);
        return int'(x) == (1 << (WIDTH - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ovf();
`ifdef SERIAL_NEG_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one accept and one completion handshake; returns what was observed.
    task automatic xfer(input logic [WIDTH-1:0] d, output int lat,
                        output logic [WIDTH-1:0] res, output logic ovf_o);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = WIDTH'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        res   = bus.out_data;
        ovf_o = get_ovf();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 00", bus.out_data); end
`ifdef SERIAL_NEG_OVF_EN
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_in_ready got %b want 0", bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int               lat;
        logic [WIDTH-1:0] res;
        logic             ovf_o;
        xfer(8'h05, lat, res, ovf_o);
        checks++; if (lat !== WIDTH) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, WIDTH); end
        checks++; if (res !== 8'hFB) begin errors++; $display("[TB] FAIL basic_data got %h want fb", res); end
`ifdef SERIAL_NEG_OVF_EN
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf got %b want 0", ovf_o); end
`endif
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_release got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_boundaries();
        logic [WIDTH-1:0] vals [4] = '{8'h00, 8'h80, 8'h7F, 8'hFF};
        int               lat;
        logic [WIDTH-1:0] res;
        logic             ovf_o;
        foreach (vals[i]) begin
            xfer(vals[i], lat, res, ovf_o);
            checks++; if (res !== ref_neg(vals[i])) begin errors++; $display("[TB] FAIL boundary_data in %h got %h want %h", vals[i], res, ref_neg(vals[i])); end
`ifdef SERIAL_NEG_OVF_EN
            checks++; if (ovf_o !== ref_ovf(vals[i])) begin errors++; $display("[TB] FAIL boundary_ovf in %h got %b want %b", vals[i], ovf_o, ref_ovf(vals[i])); end
`endif
        end
    endtask

    task automatic test_random();
        int               lat;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] res;
        logic             ovf_o;
        for (int i = 0; i < 20; i++) begin
            d = WIDTH'($urandom);
            if (i == 5) d = 8'h80;
            xfer(d, lat, res, ovf_o);
            checks++; if (lat !== WIDTH) begin errors++; $display("[TB] FAIL random_latency in %h got %0d want %0d", d, lat, WIDTH); end
            checks++; if (res !== ref_neg(d)) begin errors++; $display("[TB] FAIL random_data in %h got %h want %h", d, res, ref_neg(d)); end
`ifdef SERIAL_NEG_OVF_EN
            checks++; if (ovf_o !== ref_ovf(d)) begin errors++; $display("[TB] FAIL random_ovf in %h got %b want %b", d, ovf_o, ref_ovf(d)); end
`endif
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h05;
        tick();
        n = 0;
        while (bus.out_valid !== 1'b1 && n < MAX_WAIT) begin
            bus.in_data = WIDTH'($urandom);
            tick();
            n++;
        end
        checks++; if (n !== WIDTH) begin errors++; $display("[TB] FAIL bp_latency got %0d want %0d", n, WIDTH); end
        for (int c = 0; c < 5; c++) begin
            bus.in_data = WIDTH'($urandom);
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFB || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
                begin errors++; $display("[TB] FAIL bp_hold cycle %0d got v=%b d=%h r=%b b=%b want v=1 d=fb r=0 b=1", c, bus.out_valid, bus.out_data, bus.in_ready, bus.busy); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got v=%b b=%b want 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int               lat;
        int               seen;
        logic [WIDTH-1:0] res;
        logic             ovf_o;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== '0)
            begin errors++; $display("[TB] FAIL midreset_state got b=%b v=%b r=%b d=%h want 0 0 0 00", bus.busy, bus.out_valid, bus.in_ready, bus.out_data); end
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 2 * WIDTH; c++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midreset_no_valid got %0d pulses want 0", seen); end
        bus.out_ready = 1'b0;
        xfer(8'h01, lat, res, ovf_o);
        checks++; if (res !== 8'hFF) begin errors++; $display("[TB] FAIL midreset_next got %h want ff", res); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] expv [2] = '{8'hFF, 8'h81};
        logic [WIDTH-1:0] results [$];
        int               acc_cyc [2] = '{0, 0};
        int               n_acc = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.in_ready === 1'b1 && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (bus.out_valid === 1'b1) results.push_back(bus.out_data);
            tick();
            if (n_acc == 1) bus.in_data = 8'h7F;
            if (n_acc == 2) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        checks++; if (n_acc !== 2 || acc_cyc[1] - acc_cyc[0] !== WIDTH + 2)
            begin errors++; $display("[TB] FAIL b2b_spacing got accepts=%0d gap=%0d want 2 and %0d", n_acc, acc_cyc[1] - acc_cyc[0], WIDTH + 2); end
        checks++; if (results.size() !== 2) begin errors++; $display("[TB] FAIL b2b_count got %0d want 2", results.size()); end
        foreach (results[i]) begin
            if (i < 2) begin
                checks++; if (results[i] !== expv[i]) begin errors++; $display("[TB] FAIL b2b_data idx %0d got %h want %h", i, results[i], expv[i]); end
            end
        end
    endtask

    task automatic test_in_valid_toggle();
        logic [WIDTH-1:0] d;
        int               n;
        int               extra;
        for (int k = 0; k < 4; k++) begin
            d = WIDTH'($urandom);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            tick();
            n = 0;
            extra = 0;
            while (bus.out_valid !== 1'b1 && n < MAX_WAIT) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = WIDTH'($urandom);
                if (bus.in_valid && bus.in_ready === 1'b1) extra++;
                tick();
                n++;
            end
            checks++; if (bus.out_data !== ref_neg(d) || n !== WIDTH)
                begin errors++; $display("[TB] FAIL toggle_data in %h got %h lat %0d want %h lat %0d", d, bus.out_data, n, ref_neg(d), WIDTH); end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checks++; if (extra !== 0 || bus.busy !== 1'b0)
                begin errors++; $display("[TB] FAIL toggle_extra_accept got extra=%0d busy=%b want 0 0", extra, bus.busy); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_in_valid_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired after %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
